// File: rtl/core_lsu_pkg.sv
// ============================================================================
// core_lsu_pkg : shared constants, FSM encoding and lane helpers for the LSU
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package core_lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  // funct3[2]: zero-extend on loads
  localparam int F3_UNSIGNED_BIT = 2;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_SIZE     = 2'd1;
  localparam logic [1:0] ERR_MISALIGN = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RESPOND = 2'd2
  } lsu_state_e;

  function automatic int lane_count(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int lane_bits(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

`default_nettype wire

// File: rtl/core_lsu_lane_align.sv
// ============================================================================
// core_lsu_lane_align : byte-enable generation, store replication and load
//                       extraction/extension for a DATA_WIDTH-wide bus
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module core_lsu_lane_align
  import core_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]                         size_i,
  input  logic [lane_bits(DATA_WIDTH)-1:0]   lane_i,
  input  logic                               unsigned_i,
  input  logic [DATA_WIDTH-1:0]              wdata_i,
  input  logic [DATA_WIDTH-1:0]              rdata_i,
  output logic [lane_count(DATA_WIDTH)-1:0]  byte_en_o,
  output logic [DATA_WIDTH-1:0]              wdata_o,
  output logic [DATA_WIDTH-1:0]              rdata_o
);

  localparam int NB = lane_count(DATA_WIDTH);

  logic [NB-1:0]         size_mask;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  sign_bit;
  logic                  fill_bit;

  always_comb begin
    size_mask = '1;
    wdata_o   = wdata_i;
    unique case (size_i)
      SIZE_B: begin
        size_mask = NB'(1'b1);
        wdata_o   = {NB{wdata_i[7:0]}};
      end
      SIZE_H: begin
        size_mask = NB'(2'b11);
        wdata_o   = {(NB/2){wdata_i[15:0]}};
      end
      SIZE_W: begin
        size_mask = NB'(4'hF);
        wdata_o   = {(NB/4){wdata_i[31:0]}};
      end
      default: begin
        size_mask = '1;
        wdata_o   = wdata_i;
      end
    endcase
    byte_en_o = size_mask << lane_i;
  end

  // The kept-byte mask is the unshifted size mask once data is right-aligned.
  always_comb begin
    shifted = rdata_i >> {lane_i, 3'b000};
    unique case (size_i)
      SIZE_B:  sign_bit = shifted[7];
      SIZE_H:  sign_bit = shifted[15];
      SIZE_W:  sign_bit = shifted[31];
      default: sign_bit = shifted[DATA_WIDTH-1];
    endcase
    fill_bit = sign_bit & ~unsigned_i;
    rdata_o  = '0;
    for (int i = 0; i < NB; i++) begin
      rdata_o[8*i +: 8] = size_mask[i] ? shifted[8*i +: 8] : {8{fill_bit}};
    end
  end

endmodule

`default_nettype wire

// File: rtl/core_load_store_unit.sv
// ============================================================================
// core_load_store_unit : handshaked, wait-state-tolerant load/store master
//                        with alignment checks and a bus timeout
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module core_load_store_unit
  import core_lsu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_store,
  input  logic [2:0]                req_funct3,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  output logic                      rsp_valid,
  output logic [DATA_WIDTH-1:0]     rsp_data,
  output logic                      rsp_error,
  output logic [1:0]                rsp_error_code,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH/8-1:0]   mem_byte_en,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic                      mem_ack,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic                      busy
);

  localparam int NB    = lane_count(DATA_WIDTH);
  localparam int LW    = lane_bits(DATA_WIDTH);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST =
      CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  lsu_state_e            state_q, state_d;
  logic [1:0]            size_q, size_d;
  logic [LW-1:0]         lane_q, lane_d;
  logic                  uns_q, uns_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [NB-1:0]         mem_be_q, mem_be_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_error_q, rsp_error_d;
  logic [1:0]            rsp_code_q, rsp_code_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic [1:0]            req_size;
  logic                  req_uns;
  logic                  req_illegal;
  logic                  req_misaligned;
  logic                  is_idle;

  logic [1:0]            al_size;
  logic [LW-1:0]         al_lane;
  logic                  al_uns;
  logic [NB-1:0]         al_byte_en;
  logic [DATA_WIDTH-1:0] al_wdata;
  logic [DATA_WIDTH-1:0] al_rdata;

  assign is_idle  = (state_q == ST_IDLE);
  assign req_size = req_funct3[1:0];
  assign req_uns  = req_funct3[F3_UNSIGNED_BIT];

  // Zero-extension is meaningless for stores and for full-width loads.
  always_comb begin
    req_illegal = 1'b0;
    if (req_size == SIZE_D && DATA_WIDTH != 64)
      req_illegal = 1'b1;
    if (req_uns && (req_store || req_size == SIZE_D ||
                    (req_size == SIZE_W && DATA_WIDTH == 32)))
      req_illegal = 1'b1;
  end

  always_comb begin
    unique case (req_size)
      SIZE_B:  req_misaligned = 1'b0;
      SIZE_H:  req_misaligned = req_addr[0];
      SIZE_W:  req_misaligned = |req_addr[1:0];
      default: req_misaligned = |req_addr[2:0];
    endcase
  end

  // Steering uses live request fields while idle, captured fields afterwards.
  assign al_size = is_idle ? req_size : size_q;
  assign al_lane = is_idle ? req_addr[LW-1:0] : lane_q;
  assign al_uns  = is_idle ? req_uns : uns_q;

  core_lsu_lane_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lane_align (
    .size_i     (al_size),
    .lane_i     (al_lane),
    .unsigned_i (al_uns),
    .wdata_i    (req_wdata),
    .rdata_i    (mem_rdata),
    .byte_en_o  (al_byte_en),
    .wdata_o    (al_wdata),
    .rdata_o    (al_rdata)
  );

  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    lane_d      = lane_q;
    uns_d       = uns_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_error_d = 1'b0;
    rsp_code_d  = ERR_NONE;
    rsp_data_d  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          size_d = req_size;
          lane_d = req_addr[LW-1:0];
          uns_d  = req_uns;
          if (req_illegal) begin
            state_d     = ST_RESPOND;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
            rsp_code_d  = ERR_SIZE;
          end else if (req_misaligned) begin
            state_d     = ST_RESPOND;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
            rsp_code_d  = ERR_MISALIGN;
          end else begin
            state_d     = ST_ACCESS;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = req_store;
            mem_addr_d  = {req_addr[ADDR_WIDTH-1:LW], {LW{1'b0}}};
            mem_be_d    = al_byte_en;
            mem_wdata_d = req_store ? al_wdata : '0;
          end
        end
      end
      ST_ACCESS: begin
        if (mem_ack) begin
          state_d     = ST_RESPOND;
          mem_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = mem_we_q ? '0 : al_rdata;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == TO_LAST) begin
          state_d     = ST_RESPOND;
          mem_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
          rsp_code_d  = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESPOND: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= ST_IDLE;
      size_q      <= SIZE_B;
      lane_q      <= '0;
      uns_q       <= 1'b0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_code_q  <= ERR_NONE;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      lane_q      <= lane_d;
      uns_q       <= uns_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_code_q  <= rsp_code_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign req_ready      = is_idle;
  assign busy           = ~is_idle;
  assign mem_req        = mem_req_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_byte_en    = mem_be_q;
  assign mem_wdata      = mem_wdata_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_error      = rsp_error_q;
  assign rsp_error_code = rsp_code_q;
  assign rsp_data       = rsp_data_q;

endmodule

`default_nettype wire

// File: tb/tb_core_load_store_unit.sv
// ============================================================================
// tb_core_load_store_unit : directed bench for 32-bit and 64-bit LSU instances
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_core_load_store_unit;

  logic clk;
  logic nrst;

  logic        a_req_valid, a_req_ready, a_req_store;
  logic [2:0]  a_req_funct3;
  logic [31:0] a_req_addr, a_req_wdata;
  logic        a_rsp_valid, a_rsp_error;
  logic [31:0] a_rsp_data;
  logic [1:0]  a_rsp_code;
  logic        a_mem_req, a_mem_we, a_mem_ack, a_busy;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [3:0]  a_mem_be;

  logic        b_req_valid, b_req_ready, b_req_store;
  logic [2:0]  b_req_funct3;
  logic [31:0] b_req_addr;
  logic [63:0] b_req_wdata;
  logic        b_rsp_valid, b_rsp_error;
  logic [63:0] b_rsp_data;
  logic [1:0]  b_rsp_code;
  logic        b_mem_req, b_mem_we, b_mem_ack, b_busy;
  logic [31:0] b_mem_addr;
  logic [63:0] b_mem_wdata, b_mem_rdata;
  logic [7:0]  b_mem_be;

  int checks   = 0;
  int failures = 0;

  core_load_store_unit #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)
  ) u_dut32 (
    .clk(clk), .nrst(nrst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_store(a_req_store),
    .req_funct3(a_req_funct3), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data), .rsp_error(a_rsp_error),
    .rsp_error_code(a_rsp_code),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_byte_en(a_mem_be), .mem_wdata(a_mem_wdata), .mem_ack(a_mem_ack),
    .mem_rdata(a_mem_rdata), .busy(a_busy)
  );

  core_load_store_unit #(
    .DATA_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)
  ) u_dut64 (
    .clk(clk), .nrst(nrst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_store(b_req_store),
    .req_funct3(b_req_funct3), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .rsp_error(b_rsp_error),
    .rsp_error_code(b_rsp_code),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_byte_en(b_mem_be), .mem_wdata(b_mem_wdata), .mem_ack(b_mem_ack),
    .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request at the current negedge; return at the negedge after acceptance.
  task automatic issue32(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
    a_req_valid  = 1'b1;
    a_req_store  = st;
    a_req_funct3 = f3;
    a_req_addr   = addr;
    a_req_wdata  = wd;
    @(negedge clk);
    a_req_valid  = 1'b0;
    a_req_addr   = 32'hDEAD_BEE0;
    a_req_funct3 = 3'd0;
  endtask

  task automatic issue64(input logic [2:0] f3, input logic [31:0] addr);
    b_req_valid  = 1'b1;
    b_req_store  = 1'b0;
    b_req_funct3 = f3;
    b_req_addr   = addr;
    @(negedge clk);
    b_req_valid  = 1'b0;
  endtask

  initial begin
    nrst = 1'b0;
    a_req_valid = 0; a_req_store = 0; a_req_funct3 = 0; a_req_addr = 0; a_req_wdata = 0;
    a_mem_ack = 0; a_mem_rdata = 0;
    b_req_valid = 0; b_req_store = 0; b_req_funct3 = 0; b_req_addr = 0; b_req_wdata = 0;
    b_mem_ack = 0; b_mem_rdata = 0;
    repeat (2) @(negedge clk);

    check("rst_mem_req",   {63'd0, a_mem_req}, 64'd0);
    check("rst_mem_addr",  {32'd0, a_mem_addr}, 64'd0);
    check("rst_mem_be",    {60'd0, a_mem_be}, 64'd0);
    check("rst_rsp_valid", {63'd0, a_rsp_valid}, 64'd0);
    check("rst_req_ready", {63'd0, a_req_ready}, 64'd1);
    check("rst_busy",      {63'd0, a_busy}, 64'd0);
    nrst = 1'b1;
    @(negedge clk);

    // LB 0x1003, two wait cycles, ack with 0x80FF1234
    issue32(1'b0, 3'd0, 32'h0000_1003, 32'h0);
    check("lb_mem_req",   {63'd0, a_mem_req}, 64'd1);
    check("lb_mem_addr",  {32'd0, a_mem_addr}, 64'h1000);
    check("lb_mem_be",    {60'd0, a_mem_be}, 64'b1000);
    check("lb_mem_we",    {63'd0, a_mem_we}, 64'd0);
    check("lb_busy",      {63'd0, a_busy}, 64'd1);
    check("lb_req_ready", {63'd0, a_req_ready}, 64'd0);
    @(negedge clk);
    check("lb_wait_req",  {63'd0, a_mem_req}, 64'd1);
    check("lb_wait_rsp",  {63'd0, a_rsp_valid}, 64'd0);
    @(negedge clk);
    a_mem_ack = 1'b1; a_mem_rdata = 32'h80FF_1234;
    @(negedge clk);
    a_mem_ack = 1'b0; a_mem_rdata = 32'h0;
    check("lb_rsp_valid", {63'd0, a_rsp_valid}, 64'd1);
    check("lb_rsp_data",  {32'd0, a_rsp_data}, 64'hFFFF_FF80);
    check("lb_rsp_code",  {62'd0, a_rsp_code}, 64'd0);
    check("lb_rsp_error", {63'd0, a_rsp_error}, 64'd0);
    check("lb_req_drop",  {63'd0, a_mem_req}, 64'd0);
    @(negedge clk);
    check("lb_rsp_pulse", {63'd0, a_rsp_valid}, 64'd0);
    check("lb_ready_back", {63'd0, a_req_ready}, 64'd1);

    // SH 0x2002 with immediate ack
    issue32(1'b1, 3'd1, 32'h0000_2002, 32'h1234_ABCD);
    check("sh_mem_we",    {63'd0, a_mem_we}, 64'd1);
    check("sh_mem_be",    {60'd0, a_mem_be}, 64'b1100);
    check("sh_mem_wdata", {32'd0, a_mem_wdata}, 64'hABCD_ABCD);
    check("sh_mem_addr",  {32'd0, a_mem_addr}, 64'h2000);
    a_mem_ack = 1'b1; a_mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    a_mem_ack = 1'b0;
    check("sh_rsp_valid", {63'd0, a_rsp_valid}, 64'd1);
    check("sh_rsp_data",  {32'd0, a_rsp_data}, 64'd0);
    check("sh_rsp_error", {63'd0, a_rsp_error}, 64'd0);
    @(negedge clk);

    // Misaligned LW and illegal-size requests: no bus cycle
    issue32(1'b0, 3'd2, 32'h0000_3001, 32'h0);
    check("lw_mis_req",   {63'd0, a_mem_req}, 64'd0);
    check("lw_mis_valid", {63'd0, a_rsp_valid}, 64'd1);
    check("lw_mis_error", {63'd0, a_rsp_error}, 64'd1);
    check("lw_mis_code",  {62'd0, a_rsp_code}, 64'd2);
    @(negedge clk);
    issue32(1'b0, 3'd3, 32'h0000_3000, 32'h0);
    check("ld32_req",     {63'd0, a_mem_req}, 64'd0);
    check("ld32_code",    {62'd0, a_rsp_code}, 64'd1);
    @(negedge clk);
    issue32(1'b1, 3'd4, 32'h0000_3000, 32'h0);
    check("sbu_code",     {62'd0, a_rsp_code}, 64'd1);
    check("sbu_data",     {32'd0, a_rsp_data}, 64'd0);
    @(negedge clk);
    issue32(1'b0, 3'd6, 32'h0000_3000, 32'h0);
    check("lwu32_code",   {62'd0, a_rsp_code}, 64'd1);
    @(negedge clk);

    // Timeout: no ack, mem_req high for exactly 4 cycles
    issue32(1'b0, 3'd2, 32'h0000_4000, 32'h0);
    for (int i = 0; i < 4; i++) begin
      check("to_req_high", {63'd0, a_mem_req}, 64'd1);
      check("to_no_rsp",   {63'd0, a_rsp_valid}, 64'd0);
      @(negedge clk);
    end
    check("to_req_low",   {63'd0, a_mem_req}, 64'd0);
    check("to_rsp_valid", {63'd0, a_rsp_valid}, 64'd1);
    check("to_rsp_code",  {62'd0, a_rsp_code}, 64'd3);
    check("to_rsp_error", {63'd0, a_rsp_error}, 64'd1);
    @(negedge clk);

    // Ack in the expiry cycle wins
    issue32(1'b0, 3'd2, 32'h0000_4000, 32'h0);
    repeat (3) @(negedge clk);
    check("to_ack_req",   {63'd0, a_mem_req}, 64'd1);
    a_mem_ack = 1'b1; a_mem_rdata = 32'h1122_3344;
    @(negedge clk);
    a_mem_ack = 1'b0;
    check("to_ack_valid", {63'd0, a_rsp_valid}, 64'd1);
    check("to_ack_code",  {62'd0, a_rsp_code}, 64'd0);
    check("to_ack_data",  {32'd0, a_rsp_data}, 64'h1122_3344);
    @(negedge clk);

    // 64-bit LWU / LW at 0x8004
    issue64(3'd6, 32'h0000_8004);
    check("lwu64_be",    {56'd0, b_mem_be}, 64'hF0);
    check("lwu64_addr",  {32'd0, b_mem_addr}, 64'h8000);
    b_mem_ack = 1'b1; b_mem_rdata = 64'h8765_4321_DEAD_BEEF;
    @(negedge clk);
    b_mem_ack = 1'b0;
    check("lwu64_valid", {63'd0, b_rsp_valid}, 64'd1);
    check("lwu64_data",  b_rsp_data, 64'h0000_0000_8765_4321);
    @(negedge clk);
    issue64(3'd2, 32'h0000_8004);
    b_mem_ack = 1'b1;
    @(negedge clk);
    b_mem_ack = 1'b0;
    check("lw64_data",   b_rsp_data, 64'hFFFF_FFFF_8765_4321);
    @(negedge clk);
    issue64(3'd3, 32'h0000_8000);
    check("ld64_be",     {56'd0, b_mem_be}, 64'hFF);
    b_mem_ack = 1'b1;
    @(negedge clk);
    b_mem_ack = 1'b0;
    check("ld64_data",   b_rsp_data, 64'h8765_4321_DEAD_BEEF);
    @(negedge clk);

    // Reset in the middle of an access
    issue32(1'b0, 3'd2, 32'h0000_5000, 32'h0);
    check("rmid_req_before", {63'd0, a_mem_req}, 64'd1);
    #2 nrst = 1'b0;
    a_mem_ack = 1'b1; a_mem_rdata = 32'hCAFE_F00D;
    #1;
    check("rmid_req_async", {63'd0, a_mem_req}, 64'd0);
    @(negedge clk);
    check("rmid_no_rsp",    {63'd0, a_rsp_valid}, 64'd0);
    nrst = 1'b1;
    a_mem_ack = 1'b0;
    @(negedge clk);
    check("rmid_no_rsp2",   {63'd0, a_rsp_valid}, 64'd0);
    check("rmid_ready",     {63'd0, a_req_ready}, 64'd1);
    check("rmid_busy",      {63'd0, a_busy}, 64'd0);
    issue32(1'b0, 3'd5, 32'h0000_6002, 32'h0);
    check("post_req",       {63'd0, a_mem_req}, 64'd1);
    check("post_be",        {60'd0, a_mem_be}, 64'b1100);
    a_mem_ack = 1'b1; a_mem_rdata = 32'h9ABC_0000;
    @(negedge clk);
    a_mem_ack = 1'b0;
    check("post_valid",     {63'd0, a_rsp_valid}, 64'd1);
    check("post_data",      {32'd0, a_rsp_data}, 64'h0000_9ABC);
    check("post_code",      {62'd0, a_rsp_code}, 64'd0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/core_load_store_unit.md
Name: core_load_store_unit

Overview:
- Parametrised load/store unit for the next-generation Experiar core.
- Replaces the core's ad-hoc inline byte-mask/memoryData logic with a handshaked, wait-state-tolerant memory master.
- Adds byte-lane steering, sign/zero extension, misalignment and illegal-size detection, a bus timeout, and optional 64-bit data (RV64 LD/SD/LWU).
- Sits between the core execute stage and the core memory port.

Parameters:
- DATA_WIDTH, 32, bus/register width; legal values 32 or 64.
- ADDR_WIDTH, 32, byte address width.
- TIMEOUT_CYCLES, 255, cycles mem_req may wait for mem_ack before aborting; 0 disables the timeout.

Ports:
- clk  in  1  core clock
- nrst  in  1  asynchronous active-low reset
- req_valid  in  1  execute stage presents an access
- req_ready  out  1  unit can accept (high in IDLE only)
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V load/store funct3
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, right-aligned
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  DATA_WIDTH  extended load data; 0 for stores and errors
- rsp_error  out  1  access failed, qualified by rsp_valid
- rsp_error_code  out  2  0 ok, 1 illegal size, 2 misaligned, 3 timeout
- mem_req  out  1  bus request, held until ack
- mem_we  out  1  write enable
- mem_addr  out  ADDR_WIDTH  req_addr with the low log2(DATA_WIDTH/8) bits cleared
- mem_byte_en  out  DATA_WIDTH/8  active lanes (loads and stores)
- mem_wdata  out  DATA_WIDTH  lane-replicated store data
- mem_ack  in  1  bus completes the access; ignored while mem_req is low
- mem_rdata  in  DATA_WIDTH  read data, valid with mem_ack
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on nrst.
- Reset: state = IDLE. All registered outputs are 0: mem_req, mem_we, mem_addr, mem_byte_en, mem_wdata, rsp_*. req_ready = 1, busy = 0.
- FSM states: IDLE, ACCESS, RESPOND.
- IDLE: accept on req_valid && req_ready, then register the request.
  - Size from funct3[1:0]: 0 byte, 1 half, 2 word, 3 double.
  - Double is legal only when DATA_WIDTH == 64.
  - funct3[2] = 1 means zero-extend; legal only for loads and only for sizes below DATA_WIDTH.
  - Illegal request: go to RESPOND with code 1; no bus cycle.
  - Legal but misaligned (addr mod size != 0): go to RESPOND with code 2; no bus cycle.
  - Otherwise go to ACCESS.
- ACCESS:
  - mem_req = 1 from the cycle after acceptance.
  - mem_addr, mem_we, mem_byte_en and mem_wdata stay stable until mem_ack.
  - mem_byte_en = ((1 << size_bytes) - 1) << lane, where lane = addr low bits.
  - mem_wdata = store data replicated across all lanes at size granularity.
  - Timeout counter starts at 0 on entry and increments each cycle without ack.
  - On mem_ack: capture mem_rdata, drop mem_req, go to RESPOND with code 0.
  - When the count reaches TIMEOUT_CYCLES: drop mem_req, go to RESPOND with code 3.
  - Ack in the same cycle the timeout expires: ack wins.
- RESPOND:
  - rsp_valid = 1 for exactly one cycle; rsp_error = (code != 0).
  - Load data: mem_rdata >> (lane*8), truncated to size, then sign-extended (funct3[2] = 0) or zero-extended.
  - Next state IDLE; req_ready returns the following cycle. There are no back-to-back accepts.
- Latency:
  - Error path: rsp_valid on cycle accept+1.
  - Bus path: mem_req on accept+1; ack on cycle k gives rsp_valid on k+1.
- Reset mid-access: mem_req drops asynchronously, no rsp_valid is issued, and any in-flight ack is lost.
- req_* inputs are sampled only at acceptance; later changes are ignored.

Decomposition:
- Package core_lsu_pkg: funct3 size/extension constants, error-code constants, FSM state encoding, and a lane-count function of DATA_WIDTH.
- Sub-module core_lsu_lane_align (combinational, parametrised by DATA_WIDTH): byte-enable generation, store replication, load extraction and extension. Reused by a later instruction-fetch unit.

Test Plan:
- DW=32, LB addr 0x1003, ack after 2 wait cycles, mem_rdata 0x80FF1234 -> mem_addr 0x1000, mem_byte_en 4'b1000, mem_we 0, rsp_data 0xFFFFFF80, rsp_valid on the cycle after ack, code 0.
- DW=32, SH addr 0x2002, wdata 0x1234ABCD, immediate ack -> mem_we 1, mem_byte_en 4'b1100, mem_wdata 0xABCDABCD, rsp_data 0.
- DW=32, LW addr 0x3001 -> mem_req never rises, rsp_valid on accept+1, rsp_error 1, code 2. LD (funct3 3) -> code 1. SBU (store, funct3 4) -> code 1.
- TIMEOUT_CYCLES=4, LW 0x4000, no ack -> mem_req high exactly 4 cycles then 0, code 3. Repeat with ack on the 4th cycle -> code 0.
- DW=64, LWU addr 0x8004, mem_rdata 0x87654321_DEADBEEF -> mem_byte_en 8'hF0, rsp_data 0x00000000_87654321. LW at the same address -> 0xFFFFFFFF_87654321.
- nrst pulsed low mid-ACCESS -> mem_req 0 within the reset cycle, no rsp_valid, req_ready 1 and busy 0 after release; the next request completes normally.
